// File: rtl/memory_access_block_pkg.sv
// Shared types and opcode constants for the memory stage.
// Thumb opA_opB groups select access size; 0101 sub-codes also pick sign.
package memory_access_block_pkg;

  typedef enum logic {
    MEM_NO_WRITE = 1'b0,
    MEM_WRITE    = 1'b1
  } mem_write_signal;

  typedef enum logic {
    REG_NO_WRITE = 1'b0,
    REG_WRITE    = 1'b1
  } reg_file_write_sig;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } reg_file_data_source;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } mem_access_size;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT_RSP
  } mem_stage_state;

  localparam logic [3:0] OP_GRP_LS   = 4'b0101;
  localparam logic [3:0] OP_GRP_BYTE = 4'b0111;
  localparam logic [3:0] OP_GRP_HALF = 4'b1000;
  localparam logic [2:0] OP_LDRSB    = 3'b011;
  localparam logic [2:0] OP_LDRSH    = 3'b111;

endpackage

// File: rtl/load_store_formatter.sv
// Combinational size decode, byte-lane steering and load extension
// for little-endian Thumb loads/stores.
module load_store_formatter
  import memory_access_block_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic [6:0]      i_op,
  input  logic [1:0]      i_addr,
  input  logic [WORD-1:0] i_sdata,
  input  logic [WORD-1:0] i_rdata,
  output mem_access_size  o_size,
  output logic            o_sign,
  output logic            o_misalign,
  output logic [3:0]      o_byte_en,
  output logic [WORD-1:0] o_wdata,
  output logic [WORD-1:0] o_ldata
);

  logic [3:0]  w_grp;
  logic [2:0]  w_sub;
  logic [7:0]  w_b;
  logic [15:0] w_h;

  assign w_grp = i_op[6:3];
  assign w_sub = i_op[2:0];
  assign w_b   = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_h   = i_rdata[{i_addr[1], 4'b0000} +: 16];

  assign o_sign = (w_grp == OP_GRP_LS) &&
                  (w_sub == OP_LDRSB || w_sub == OP_LDRSH);

  always_comb begin
    o_size = SIZE_WORD;
    unique case (1'b1)
      (w_grp == OP_GRP_LS): begin
        unique case (w_sub)
          3'b000, 3'b100:         o_size = SIZE_WORD;
          3'b010, 3'b011, 3'b110: o_size = SIZE_BYTE;
          default:                o_size = SIZE_HALF;
        endcase
      end
      (w_grp == OP_GRP_BYTE): o_size = SIZE_BYTE;
      (w_grp == OP_GRP_HALF): o_size = SIZE_HALF;
      default:                o_size = SIZE_WORD;
    endcase
  end

  assign o_misalign = (o_size == SIZE_HALF && i_addr[0]) ||
                      (o_size == SIZE_WORD && i_addr != 2'b00);

  always_comb begin
    o_byte_en = 4'b1111;
    o_wdata   = i_sdata;
    o_ldata   = i_rdata;
    unique case (o_size)
      SIZE_BYTE: begin
        o_byte_en = 4'b0001 << i_addr;
        o_wdata   = {(WORD/8){i_sdata[7:0]}};
        o_ldata   = {{(WORD-8){o_sign & w_b[7]}}, w_b};
      end
      SIZE_HALF: begin
        o_byte_en = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {(WORD/16){i_sdata[15:0]}};
        o_ldata   = {{(WORD-16){o_sign & w_h[15]}}, w_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access_block.sv
// Memory stage: issues data-memory requests from EX/MEM, stalls while
// memory is busy, and drives the MEM/WB pipeline register.
module memory_access_block
  import memory_access_block_pkg::*;
#(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  is_valid_i,
  input  mem_write_signal       mem_write_en_i,
  input  reg_file_write_sig     reg_file_write_en_i,
  input  reg_file_data_source   reg_file_data_source_i,
  input  logic [6:0]            opA_opB_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
  input  logic [WORD-1:0]       alu_result_i,
  input  logic [WORD-1:0]       store_data_i,
  output logic                  dmem_req_valid_o,
  input  logic                  dmem_req_ready_i,
  output logic [WORD-1:0]       dmem_addr_o,
  output logic                  dmem_wr_en_o,
  output logic [3:0]            dmem_byte_en_o,
  output logic [WORD-1:0]       dmem_wdata_o,
  input  logic                  dmem_rsp_valid_i,
  input  logic [WORD-1:0]       dmem_rdata_i,
  output logic                  stall_o,
  output logic                  is_valid_o,
  output reg_file_write_sig     reg_file_write_en_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic [WORD-1:0]       reg_data_o,
  output logic                  align_fault_o
);

  mem_stage_state    r_state, w_next;
  logic              r_valid;
  reg_file_write_sig r_we;
  logic [ADDR_WIDTH-1:0] r_dest;
  logic [WORD-1:0]   r_data;
  logic              r_fault;

  mem_access_size    w_size;
  logic              w_sign;
  logic              w_misalign;
  logic [3:0]        w_be;
  logic [WORD-1:0]   w_wdata;
  logic [WORD-1:0]   w_ldata;

  logic              w_store;
  logic              w_load;
  logic              w_access;
  logic              w_req;
  logic              w_stall;
  logic              w_wb_load;
  reg_file_write_sig w_wb_we;
  logic [WORD-1:0]   w_wb_data;
  logic              w_fault;

  load_store_formatter #(
    .WORD(WORD)
  ) u_fmt (
    .i_op       (opA_opB_i),
    .i_addr     (alu_result_i[1:0]),
    .i_sdata    (store_data_i),
    .i_rdata    (dmem_rdata_i),
    .o_size     (w_size),
    .o_sign     (w_sign),
    .o_misalign (w_misalign),
    .o_byte_en  (w_be),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata)
  );

  assign w_store  = (mem_write_en_i == MEM_WRITE);
  assign w_load   = (reg_file_data_source_i == SRC_MEM);
  assign w_access = is_valid_i && (w_store || w_load);

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_stall   = 1'b0;
    w_wb_load = 1'b0;
    w_wb_we   = reg_file_write_en_i;
    w_wb_data = alu_result_i;
    w_fault   = 1'b0;
    unique case (r_state)
      MEM_IDLE: begin
        if (w_access && w_misalign) begin
          w_wb_load = 1'b1;
          w_wb_we   = REG_NO_WRITE;
          w_fault   = 1'b1;
        end else if (w_access) begin
          w_req = 1'b1;
          if (!dmem_req_ready_i) begin
            w_stall = 1'b1;
          end else if (w_store) begin
            w_wb_load = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_next  = MEM_WAIT_RSP;
          end
        end else if (is_valid_i) begin
          w_wb_load = 1'b1;
        end
      end
      MEM_WAIT_RSP: begin
        if (dmem_rsp_valid_i) begin
          w_wb_load = 1'b1;
          w_wb_data = w_ldata;
          w_next    = MEM_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= MEM_IDLE;
      r_valid <= 1'b0;
      r_we    <= REG_NO_WRITE;
      r_dest  <= '0;
      r_data  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault;
      if (w_wb_load) begin
        r_valid <= 1'b1;
        r_we    <= w_wb_we;
        r_dest  <= reg_dest_addr_i;
        r_data  <= w_wb_data;
      end else begin
        r_valid <= 1'b0;
        r_we    <= REG_NO_WRITE;
      end
    end
  end

  // loads read the whole word; lane selection happens on the response
  assign dmem_req_valid_o    = w_req;
  assign dmem_addr_o         = {alu_result_i[WORD-1:2], 2'b00};
  assign dmem_wr_en_o        = w_store;
  assign dmem_byte_en_o      = w_store ? w_be : 4'b1111;
  assign dmem_wdata_o        = w_wdata;
  assign stall_o             = w_stall;
  assign is_valid_o          = r_valid;
  assign reg_file_write_en_o = r_we;
  assign reg_dest_addr_o     = r_dest;
  assign reg_data_o          = r_data;
  assign align_fault_o       = r_fault;

endmodule

// File: tb/tb_memory_access_block.sv
// Bench for memory_access_block: directed scenarios plus a scoreboard
// of expected MEM/WB writes matched against observed writes.
module tb_memory_access_block;
  import memory_access_block_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                is_valid_i;
  mem_write_signal     mem_we;
  reg_file_write_sig   rf_we;
  reg_file_data_source src;
  logic [6:0]          op;
  logic [3:0]          dest;
  logic [31:0]         alu;
  logic [31:0]         sdata;
  logic                ready;
  logic                rsp_valid;
  logic [31:0]         rdata;

  logic                req_valid;
  logic [31:0]         d_addr;
  logic                d_wr;
  logic [3:0]          d_be;
  logic [31:0]         d_wdata;
  logic                stall;
  logic                v_out;
  reg_file_write_sig   we_out;
  logic [3:0]          dest_out;
  logic [31:0]         data_out;
  logic                fault;

  memory_access_block #(.WORD(32), .ADDR_WIDTH(4)) dut (
    .clk_i                  (clk),
    .reset_n_i              (rst_n),
    .is_valid_i             (is_valid_i),
    .mem_write_en_i         (mem_we),
    .reg_file_write_en_i    (rf_we),
    .reg_file_data_source_i (src),
    .opA_opB_i              (op),
    .reg_dest_addr_i        (dest),
    .alu_result_i           (alu),
    .store_data_i           (sdata),
    .dmem_req_valid_o       (req_valid),
    .dmem_req_ready_i       (ready),
    .dmem_addr_o            (d_addr),
    .dmem_wr_en_o           (d_wr),
    .dmem_byte_en_o         (d_be),
    .dmem_wdata_o           (d_wdata),
    .dmem_rsp_valid_i       (rsp_valid),
    .dmem_rdata_i           (rdata),
    .stall_o                (stall),
    .is_valid_o             (v_out),
    .reg_file_write_en_o    (we_out),
    .reg_dest_addr_o        (dest_out),
    .reg_data_o             (data_out),
    .align_fault_o          (fault)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  dest;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  wb_t obs_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  always @(negedge clk)
    if (rst_n === 1'b1 && v_out === 1'b1)
      obs_q.push_back('{we: we_out, dest: dest_out, data: data_out});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    is_valid_i = 1'b0;
    mem_we     = MEM_NO_WRITE;
    rf_we      = REG_NO_WRITE;
    src        = SRC_ALU;
    op         = 7'd0;
    dest       = 4'd0;
    alu        = 32'd0;
    sdata      = 32'd0;
    ready      = 1'b0;
    rsp_valid  = 1'b0;
    rdata      = 32'd0;
  endtask

  task automatic drive(input logic [6:0] o, input logic st, input logic ld,
                       input logic w, input logic [3:0] d,
                       input logic [31:0] a);
    is_valid_i = 1'b1;
    op         = o;
    mem_we     = st ? MEM_WRITE : MEM_NO_WRITE;
    src        = ld ? SRC_MEM : SRC_ALU;
    rf_we      = w ? REG_WRITE : REG_NO_WRITE;
    dest       = d;
    alu        = a;
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] o,
                                           input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (8 * a));
    h = a[1] ? d[31:16] : d[15:0];
    case (o)
      3'b100:  return d;
      3'b101:  return {16'h0, h};
      3'b111:  return {{16{h[15]}}, h};
      3'b110:  return {24'h0, b};
      default: return {{24{b[7]}}, b};
    endcase
  endfunction

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if (stall !== 1'b0 || req_valid !== 1'b0 || fault !== 1'b0)
      $display("FAIL reset_ctrl got stall=%b req=%b fault=%b want 0",
               stall, req_valid, fault);
    else pass_cnt++;
    total_cnt++;
    if (v_out !== 1'b0 || we_out !== REG_NO_WRITE)
      $display("FAIL reset_wb got v=%b we=%b want 0/0", v_out, we_out);
    else pass_cnt++;
    total_cnt++;
    if (dest_out !== 4'd0 || data_out !== 32'd0)
      $display("FAIL reset_data got d=%h x=%h want 0", dest_out, data_out);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_strb();
    drive(7'b0101_010, 1'b1, 1'b0, 1'b0, 4'd3, 32'h103);
    sdata = 32'h0000_00AB;
    ready = 1'b1;
    #1;
    total_cnt++;
    if (req_valid !== 1'b1 || d_wr !== 1'b1 || stall !== 1'b0)
      $display("FAIL strb_req got req=%b wr=%b stall=%b want 1/1/0",
               req_valid, d_wr, stall);
    else pass_cnt++;
    total_cnt++;
    if (d_be !== 4'b1000 || d_wdata !== 32'hABAB_ABAB || d_addr !== 32'h100)
      $display("FAIL strb_lanes got be=%b wd=%h a=%h want 1000 abababab 100",
               d_be, d_wdata, d_addr);
    else pass_cnt++;
    exp_q.push_back('{we: 1'b0, dest: 4'd3, data: 32'h103});
    step();
    idle();
    total_cnt++;
    if (v_out !== 1'b1)
      $display("FAIL strb_wb got v=%b want 1", v_out);
    else pass_cnt++;
    step();
  endtask

  task automatic test_ldrsh();
    int st_cnt = 0;
    drive(7'b0101_111, 1'b0, 1'b1, 1'b1, 4'd5, 32'h202);
    ready = 1'b1;
    #1;
    total_cnt++;
    if (req_valid !== 1'b1 || d_be !== 4'b1111 || d_addr !== 32'h200)
      $display("FAIL ldrsh_req got req=%b be=%b a=%h want 1 1111 200",
               req_valid, d_be, d_addr);
    else pass_cnt++;
    if (stall === 1'b1) st_cnt++;
    step();
    ready = 1'b0;
    #1;
    if (stall === 1'b1) st_cnt++;
    total_cnt++;
    if (req_valid !== 1'b0 || v_out !== 1'b0)
      $display("FAIL ldrsh_wait got req=%b v=%b want 0/0", req_valid, v_out);
    else pass_cnt++;
    step();
    rsp_valid = 1'b1;
    rdata     = 32'h8001_FFFF;
    #1;
    if (stall === 1'b1) st_cnt++;
    total_cnt++;
    if (st_cnt != 2 || v_out !== 1'b0)
      $display("FAIL ldrsh_stall got %0d cycles v=%b want 2 cycles v=0",
               st_cnt, v_out);
    else pass_cnt++;
    exp_q.push_back('{we: 1'b1, dest: 4'd5, data: 32'hFFFF_8001});
    step();
    idle();
    total_cnt++;
    if (v_out !== 1'b1 || we_out !== REG_WRITE || data_out !== 32'hFFFF_8001)
      $display("FAIL ldrsh_wb got v=%b we=%b d=%h want 1 1 ffff8001",
               v_out, we_out, data_out);
    else pass_cnt++;
    step();
  endtask

  task automatic test_ldr_backpressure();
    int st_cnt = 0;
    int req_ok = 0;
    drive(7'b0110_100, 1'b0, 1'b1, 1'b1, 4'd9, 32'h40C);
    for (int c = 0; c < 4; c++) begin
      ready = (c == 3);
      #1;
      if (stall === 1'b1) st_cnt++;
      if (req_valid === 1'b1 && d_addr === 32'h40C) req_ok++;
      step();
    end
    ready     = 1'b0;
    rsp_valid = 1'b1;
    rdata     = 32'hDEAD_BEEF;
    #1;
    if (stall === 1'b1) st_cnt++;
    total_cnt++;
    if (req_ok != 4 || st_cnt != 4)
      $display("FAIL ldr_bp got req=%0d stall=%0d want 4/4", req_ok, st_cnt);
    else pass_cnt++;
    exp_q.push_back('{we: 1'b1, dest: 4'd9, data: 32'hDEAD_BEEF});
    step();
    idle();
    step();
  endtask

  task automatic test_misalign();
    drive(7'b0101_101, 1'b0, 1'b1, 1'b1, 4'd7, 32'h301);
    ready = 1'b1;
    #1;
    total_cnt++;
    if (req_valid !== 1'b0 || stall !== 1'b0)
      $display("FAIL mis_req got req=%b stall=%b want 0/0", req_valid, stall);
    else pass_cnt++;
    exp_q.push_back('{we: 1'b0, dest: 4'd7, data: 32'h301});
    step();
    idle();
    total_cnt++;
    if (fault !== 1'b1 || v_out !== 1'b1 || we_out !== REG_NO_WRITE)
      $display("FAIL mis_wb got f=%b v=%b we=%b want 1 1 0",
               fault, v_out, we_out);
    else pass_cnt++;
    step();
    total_cnt++;
    if (fault !== 1'b0)
      $display("FAIL mis_pulse got %b want 0", fault);
    else pass_cnt++;
  endtask

  task automatic test_alu();
    drive(7'b0001_100, 1'b0, 1'b0, 1'b1, 4'd2, 32'h1234);
    ready = 1'b1;
    #1;
    total_cnt++;
    if (req_valid !== 1'b0 || stall !== 1'b0)
      $display("FAIL alu_req got req=%b stall=%b want 0/0", req_valid, stall);
    else pass_cnt++;
    exp_q.push_back('{we: 1'b1, dest: 4'd2, data: 32'h1234});
    step();
    is_valid_i = 1'b0;
    total_cnt++;
    if (data_out !== 32'h1234 || v_out !== 1'b1)
      $display("FAIL alu_wb got d=%h v=%b want 1234 1", data_out, v_out);
    else pass_cnt++;
    step();
    total_cnt++;
    if (v_out !== 1'b0 || we_out !== REG_NO_WRITE)
      $display("FAIL bubble got v=%b we=%b want 0/0", v_out, we_out);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[6];
    logic [1:0]  a;
    logic [31:0] d;
    ops = '{3'b011, 3'b111, 3'b100, 3'b101, 3'b110, 3'b011};
    for (int k = 0; k < 6; k++) begin
      a = 2'($urandom_range(0, 3));
      if (ops[k] == 3'b100) a = 2'b00;
      if (ops[k][0] && ops[k] != 3'b011) a[0] = 1'b0;
      d = $urandom | (k[0] ? 32'h0 : 32'h8080_8080);
      drive({4'b0101, ops[k]}, 1'b0, 1'b1, 1'b1, 4'(k + 8),
            32'h600 + 32'(a));
      ready     = 1'b1;
      rsp_valid = 1'b0;
      step();
      rsp_valid = 1'b1;
      rdata     = d;
      exp_q.push_back('{we: 1'b1, dest: 4'(k + 8),
                        data: ld_model(ops[k], a, d)});
      step();
    end
    idle();
    step();
  endtask

  task automatic test_reset_in_wait();
    drive(7'b0101_100, 1'b0, 1'b1, 1'b1, 4'd4, 32'h500);
    ready = 1'b1;
    step();
    idle();
    #1;
    total_cnt++;
    if (stall !== 1'b1)
      $display("FAIL rst_wait_pre got stall=%b want 1", stall);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (stall !== 1'b0 || req_valid !== 1'b0 || v_out !== 1'b0 ||
        data_out !== 32'd0)
      $display("FAIL rst_wait got st=%b req=%b v=%b d=%h want 0",
               stall, req_valid, v_out, data_out);
    else pass_cnt++;
    step();
    rst_n     = 1'b1;
    rsp_valid = 1'b1;
    rdata     = 32'hCAFE_F00D;
    #1;
    total_cnt++;
    if (stall !== 1'b0 || req_valid !== 1'b0)
      $display("FAIL late_rsp got st=%b req=%b want 0/0", stall, req_valid);
    else pass_cnt++;
    step();
    rsp_valid = 1'b0;
    total_cnt++;
    if (v_out !== 1'b0 || we_out !== REG_NO_WRITE)
      $display("FAIL late_rsp_wb got v=%b we=%b want 0/0", v_out, we_out);
    else pass_cnt++;
    step();
  endtask

  task automatic test_scoreboard();
    wb_t e;
    int  n_obs;
    n_obs = obs_q.size();
    total_cnt++;
    if (n_obs != exp_q.size())
      $display("FAIL sb_count got %0d want %0d", n_obs, exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < n_obs && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q[i] !== e)
        $display("FAIL sb_wb%0d got we=%b d=%0d x=%h want we=%b d=%0d x=%h",
                 i, obs_q[i].we, obs_q[i].dest, obs_q[i].data,
                 e.we, e.dest, e.data);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_strb();
    test_ldrsh();
    test_ldr_backpressure();
    test_misalign();
    test_alu();
    test_back_to_back();
    test_reset_in_wait();
    test_scoreboard();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
